// File: rtl/chunk_sequencer.sv
// Chunk sequencer: IDLE -> ARM (init0) -> RUN (CHUNKS stallable shift strobes) -> DONE (one-cycle pulse).
// Optional abort of ARM/RUN is enabled by defining CHUNK_SEQ_ABORT_EN; abort is ignored otherwise.
module chunk_sequencer #(
    parameter int CHUNKS = 4,
    parameter int IDX_W  = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stall,
    input  logic             abort,
    output logic             result_ready,
    output logic             init0,
    output logic             shift_en,
    output logic [IDX_W-1:0] chunk_idx,
    output logic             last_chunk,
    output logic             done
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ARM  = 2'd1,
        S_RUN  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(CHUNKS - 1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [IDX_W-1:0] r_idx;
    logic [IDX_W-1:0] w_idx_nxt;
    logic             w_abort;

`ifdef CHUNK_SEQ_ABORT_EN
    assign w_abort = abort;
`else
    logic w_unused_abort;
    assign w_unused_abort = abort;
    assign w_abort        = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_idx   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_idx_nxt    = r_idx;
        result_ready = 1'b0;
        init0        = 1'b0;
        shift_en     = 1'b0;
        last_chunk   = 1'b0;
        done         = 1'b0;
        case (r_state)
            S_IDLE: begin
                result_ready = 1'b1;
                if (start) begin
                    w_state_nxt = S_ARM;
                end
            end
            S_ARM: begin
                init0 = 1'b1;
                if (w_abort) begin
                    w_state_nxt = S_IDLE;
                    w_idx_nxt   = '0;
                end else if (!start) begin
                    w_state_nxt = S_RUN;
                    w_idx_nxt   = '0;
                end
            end
            S_RUN: begin
                last_chunk = (r_idx == LAST_IDX);
                // Abort outranks both stall and completion, and suppresses the strobe.
                if (w_abort) begin
                    w_state_nxt = S_IDLE;
                    w_idx_nxt   = '0;
                end else if (!stall) begin
                    shift_en = 1'b1;
                    if (r_idx == LAST_IDX) begin
                        w_state_nxt = S_DONE;
                        w_idx_nxt   = '0;
                    end else begin
                        w_idx_nxt = r_idx + IDX_W'(1);
                    end
                end
            end
            S_DONE: begin
                done        = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_idx_nxt   = '0;
            end
        endcase
    end

    assign chunk_idx = r_idx;

endmodule

// File: tb/tb_chunk_sequencer.sv
// Bench for chunk_sequencer: CHUNKS=4 and CHUNKS=1 instances share one directed stimulus,
// checked every cycle against a phase/count model plus hand-computed literal expectations.
module tb_chunk_sequencer;

    logic clk = 1'b0;
    logic rst, start, stall, abort;
    always #5 clk = ~clk;

    logic       rr0, in0, sh0, lc0, dn0;
    logic [1:0] ix0;
    logic       rr1, in1, sh1, lc1, dn1;
    logic [0:0] ix1;

    chunk_sequencer #(.CHUNKS(4), .IDX_W(2)) u_dut4 (
        .clk(clk), .rst(rst), .start(start), .stall(stall), .abort(abort),
        .result_ready(rr0), .init0(in0), .shift_en(sh0), .chunk_idx(ix0),
        .last_chunk(lc0), .done(dn0)
    );

    chunk_sequencer #(.CHUNKS(1), .IDX_W(1)) u_dut1 (
        .clk(clk), .rst(rst), .start(start), .stall(stall), .abort(abort),
        .result_ready(rr1), .init0(in1), .shift_en(sh1), .chunk_idx(ix1),
        .last_chunk(lc1), .done(dn1)
    );

`ifdef CHUNK_SEQ_ABORT_EN
    localparam bit ABORT_ON = 1'b1;
`else
    localparam bit ABORT_ON = 1'b0;
`endif

    // Model: phase 0=idle 1=arming 2=shifting 3=finished; cnt = shifts completed this operation.
    int nch [2] = '{4, 1};
    int m_ph [2];
    int m_cnt[2];
    bit chk_en = 1'b0;
    int cyc = 0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                m_ph[i]  <= 0;
                m_cnt[i] <= 0;
            end else if (m_ph[i] == 0) begin
                if (start) m_ph[i] <= 1;
            end else if (m_ph[i] == 1) begin
                if (ABORT_ON && abort) m_ph[i] <= 0;
                else if (!start) begin
                    m_ph[i]  <= 2;
                    m_cnt[i] <= 0;
                end
            end else if (m_ph[i] == 2) begin
                if (ABORT_ON && abort) begin
                    m_ph[i]  <= 0;
                    m_cnt[i] <= 0;
                end else if (!stall) begin
                    if (m_cnt[i] + 1 == nch[i]) begin
                        m_ph[i]  <= 3;
                        m_cnt[i] <= 0;
                    end else begin
                        m_cnt[i] <= m_cnt[i] + 1;
                    end
                end
            end else begin
                m_ph[i] <= 0;
            end
        end
    end

    int mv = 0, me = 0;
    int lv = 0, le = 0;

    task automatic cmp(input string nm, input int inst, input int act, input int exp);
        mv++;
        if (act != exp) begin
            me++;
            $display("FAIL %s[dut%0d] cyc=%0d: got %0d expected %0d", nm, inst, cyc, act, exp);
        end
    endtask

    int n_shift[2] = '{0, 0};
    int n_done [2] = '{0, 0};
    int n_init [2] = '{0, 0};
    int n_last [2] = '{0, 0};
    int done_cyc[2] = '{-1, -1};

    always @(negedge clk) begin
        if (chk_en) begin
            int a [2][6];
            a[0] = '{int'(rr0), int'(in0), int'(sh0), int'(ix0), int'(lc0), int'(dn0)};
            a[1] = '{int'(rr1), int'(in1), int'(sh1), int'(ix1), int'(lc1), int'(dn1)};
            for (int i = 0; i < 2; i++) begin
                cmp("result_ready", i, a[i][0], int'(m_ph[i] == 0));
                cmp("init0",        i, a[i][1], int'(m_ph[i] == 1));
                cmp("shift_en",     i, a[i][2], int'(m_ph[i] == 2 && !stall && !(ABORT_ON && abort)));
                cmp("chunk_idx",    i, a[i][3], m_cnt[i]);
                cmp("last_chunk",   i, a[i][4], int'(m_ph[i] == 2 && m_cnt[i] == nch[i] - 1));
                cmp("done",         i, a[i][5], int'(m_ph[i] == 3));
                if (a[i][2] == 1) n_shift[i] <= n_shift[i] + 1;
                if (a[i][1] == 1) n_init[i]  <= n_init[i] + 1;
                if (a[i][5] == 1) begin
                    n_done[i]   <= n_done[i] + 1;
                    done_cyc[i] <= cyc;
                end
                if (a[i][2] == 1 && a[i][4] == 1 && a[i][3] == nch[i] - 1) n_last[i] <= n_last[i] + 1;
            end
        end
    end

    task automatic lit(input string nm, input int act, input int exp);
        lv++;
        if (act != exp) begin
            le++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    int b_sh[2], b_dn[2], b_in[2], b_ls[2];
    int c0;

    task automatic snap();
        for (int i = 0; i < 2; i++) begin
            b_sh[i] = n_shift[i];
            b_dn[i] = n_done[i];
            b_in[i] = n_init[i];
            b_ls[i] = n_last[i];
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; stall = 1'b0; abort = 1'b0;
        tick(1);
        chk_en = 1'b1;
        tick(1);
        rst = 1'b0;
        tick(2);

        // Reset then idle.
        #1;
        lit("reset_result_ready", int'(rr0), 1);
        lit("reset_outputs_zero", int'({in0, sh0, lc0, dn0}), 0);
        lit("reset_chunk_idx",    int'(ix0), 0);

        // Plain operation: start held three cycles.
        snap();
        start = 1'b1; tick(3);
        start = 1'b0; c0 = cyc;
        tick(8);
        lit("plain_init0_cycles",  n_init[0] - b_in[0], 3);
        lit("plain_shift_pulses",  n_shift[0] - b_sh[0], 4);
        lit("plain_last_on_idx3",  n_last[0] - b_ls[0], 1);
        lit("plain_done_pulses",   n_done[0] - b_dn[0], 1);
        lit("plain_latency",       done_cyc[0] - c0, 5);
        lit("plain_ready_back",    int'(rr0), 1);
        lit("c1_shift_pulses",     n_shift[1] - b_sh[1], 1);
        lit("c1_last_pulses",      n_last[1] - b_ls[1], 1);
        lit("c1_latency",          done_cyc[1] - c0, 2);

        // Stalls on idx 2 and idx 3.
        snap();
        start = 1'b1; tick(1);
        start = 1'b0; c0 = cyc;
        tick(3);
        stall = 1'b1; #1;
        lit("stall_idx_held",  int'(ix0), 2);
        lit("stall_no_shift",  int'(sh0), 0);
        tick(2);
        stall = 1'b0; tick(1);
        stall = 1'b1; #1;
        lit("stall_last_held", int'(ix0), 3);
        lit("stall_last_flag", int'(lc0), 1);
        tick(2);
        stall = 1'b0;
        tick(4);
        lit("stall_shift_pulses", n_shift[0] - b_sh[0], 4);
        lit("stall_done_pulses",  n_done[0] - b_dn[0], 1);
        lit("stall_latency",      done_cyc[0] - c0, 9);

        // Reset in the middle of RUN.
        snap();
        start = 1'b1; tick(1);
        start = 1'b0; tick(2);
        lit("rst_mid_idx_before", int'(ix0), 1);
        rst = 1'b1; tick(1);
        rst = 1'b0; #1;
        lit("rst_mid_ready", int'(rr0), 1);
        lit("rst_mid_idx",   int'(ix0), 0);
        tick(4);
        lit("rst_mid_no_done", n_done[0] - b_dn[0], 0);

        // Abort with stall on idx 2.
        snap();
        start = 1'b1; tick(1);
        start = 1'b0; tick(3);
        stall = 1'b1; abort = 1'b1; #1;
        lit("abort_no_shift", int'(sh0), 0);
        tick(1);
        abort = 1'b0; #1;
        if (ABORT_ON) begin
            lit("abort_to_idle", int'(rr0), 1);
            lit("abort_idx_zero", int'(ix0), 0);
        end else begin
            lit("abort_ignored_idx", int'(ix0), 2);
        end
        stall = 1'b0;
        tick(6);
        lit("abort_done_pulses",  n_done[0] - b_dn[0], ABORT_ON ? 0 : 1);
        lit("abort_shift_pulses", n_shift[0] - b_sh[0], ABORT_ON ? 2 : 4);

        // Abort while idle does nothing.
        abort = 1'b1; tick(2);
        abort = 1'b0; #1;
        lit("abort_idle_ready", int'(rr0), 1);

        // start re-asserted during RUN and held through DONE.
        snap();
        start = 1'b1; tick(1);
        start = 1'b0; tick(1);
        start = 1'b1; tick(6);
        start = 1'b0; tick(6);
        lit("rearm_shift_pulses", n_shift[0] - b_sh[0], 8);
        lit("rearm_done_pulses",  n_done[0] - b_dn[0], 2);

        tick(2);
        $display("== %0d vectors applied, %0d miscompares ==", mv + lv, me + le);
        $finish;
    end

endmodule

// File: doc/chunk_sequencer.md
CHUNK_SEQUENCER -- requirements
Module: chunk_sequencer

Interface
REQ-001 SHALL have parameter CHUNKS, default 4, number of shift cycles per operation; legal range 1..2**IDX_W.
REQ-002 SHALL have parameter IDX_W, default 2, width of chunk_idx.
REQ-003 SHALL have port clk  input  1  clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port start  input  1  operation request; level-sensitive, press/release handshake.
REQ-006 SHALL have port stall  input  1  holds progress during RUN when high.
REQ-007 SHALL have port abort  input  1  cancels an operation in progress (functional only with CHUNK_SEQ_ABORT_EN).
REQ-008 SHALL have port result_ready  output  1  high when idle and previous result valid.
REQ-009 SHALL have port init0  output  1  datapath initialise strobe.
REQ-010 SHALL have port shift_en  output  1  datapath shift strobe, one per chunk.
REQ-011 SHALL have port chunk_idx  output  IDX_W  index of current chunk, 0..CHUNKS-1.
REQ-012 SHALL have port last_chunk  output  1  high in RUN while chunk_idx==CHUNKS-1.
REQ-013 SHALL have port done  output  1  single-cycle completion pulse.

Function
REQ-014 SHALL implement states IDLE, ARM, RUN, DONE.
REQ-015 IDLE: result_ready=1; start=1 -> ARM, else stay.
REQ-016 ARM: init0=1; stays while start=1; start=0 -> RUN with chunk_idx loaded to 0.
REQ-017 RUN: shift_en = ~stall (combinational from stall, Mealy); chunk_idx increments by 1 on each cycle with shift_en=1.
REQ-018 RUN: shift_en=1 with chunk_idx==CHUNKS-1 -> DONE; chunk_idx returns to 0.
REQ-019 RUN with stall=1: no shift_en, chunk_idx and state hold, including on the last chunk.
REQ-020 DONE: done=1 for exactly one cycle, then unconditionally -> IDLE.
REQ-021 All outputs not listed as high for a state SHALL be 0 in that state; result_ready is 0 in ARM, RUN and DONE.
REQ-022 start SHALL be ignored in RUN and DONE; a start held through DONE begins a new ARM on the first IDLE cycle it is sampled.
REQ-023 Exactly CHUNKS shift_en pulses SHALL occur per completed operation; with no stalls, latency from start falling to done is CHUNKS+1 cycles.
REQ-024 CHUNKS=1 SHALL give one shift_en cycle with last_chunk=1, then DONE.
REQ-025 chunk_idx SHALL never exceed CHUNKS-1, and SHALL not wrap inside an operation.

Reset
REQ-026 With rst=1 at a clock edge, state SHALL become IDLE and chunk_idx 0, from any state, overriding start, stall and abort.
REQ-027 After reset: result_ready=1, init0=0, shift_en=0, last_chunk=0, done=0.

Configuration
REQ-028 Macro CHUNK_SEQ_ABORT_EN, when defined, SHALL make abort=1 in ARM or RUN force next state IDLE with chunk_idx=0 and no done pulse; abort SHALL take priority over stall and completion, and shift_en SHALL be 0 in that cycle.
REQ-029 Without CHUNK_SEQ_ABORT_EN, abort SHALL be ignored entirely, with behaviour identical to abort tied 0.
REQ-030 abort in IDLE or DONE SHALL have no effect in either build.

Verification
REQ-031 Reset then idle, CHUNKS=4 -> result_ready=1, all other outputs 0, chunk_idx=0.
REQ-032 start high 3 cycles, then low, no stall -> init0 high 3 cycles; shift_en high 4 consecutive cycles with chunk_idx 0,1,2,3 and last_chunk on idx 3; done 1 cycle; result_ready returns.
REQ-033 stall=1 for 2 cycles while chunk_idx=2, and again on idx 3 -> chunk_idx holds and shift_en=0 during stalls; still exactly 4 shift_en pulses, done after the final one.
REQ-034 rst pulsed during RUN at chunk_idx=1 -> next cycle IDLE, chunk_idx=0, no done, result_ready=1.
REQ-035 CHUNK_SEQ_ABORT_EN defined, abort=1 at chunk_idx=2 with stall=1 -> IDLE next cycle, no done; same stimulus without the macro -> operation completes normally.
REQ-036 CHUNKS=1, IDX_W=1 -> one shift_en with last_chunk=1 and chunk_idx=0, then done.
